// File: rtl/gesture_toggle_generator.sv
// Gesture front end: sync, optional debounce (GESTURE_DEBOUNCE_EN), edge detect, two-step sequencer.
// Emits first/second toggle pulses, an armed flag and a window timeout pulse.
module gesture_toggle_generator #(
  parameter int unsigned           DEBOUNCE_CYCLES = 8,
  parameter int unsigned           MODE_WIDTH      = 2,
  parameter int unsigned           MAX_WIDTH       = 8,
  parameter logic [MODE_WIDTH-1:0] OFF_MODE        = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  left_sensor_raw,
  input  logic                  right_sensor_raw,
  input  logic [MODE_WIDTH-1:0] current_mode,
  input  logic [MAX_WIDTH-1:0]  gesture_window,
  output logic                  first_toggle_signal,
  output logic                  second_toggle_signal,
  output logic                  gesture_armed,
  output logic                  gesture_timeout
);

  localparam logic [MAX_WIDTH-1:0] WinOne = {{(MAX_WIDTH-1){1'b0}}, 1'b1};

  // Bit 0 is the left channel, bit 1 the right channel.
  logic [1:0] raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] filt, filt_prev_q;
  logic [1:0] edge_det;
  logic       left_edge, right_edge;

  assign raw = {right_sensor_raw, left_sensor_raw};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_prev_q <= '0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      filt_prev_q <= filt;
    end
  end

`ifdef GESTURE_DEBOUNCE_EN
  localparam logic [7:0] DbLast = 8'(DEBOUNCE_CYCLES - 1);

  logic [1:0] filt_q;
  logic [7:0] db_cnt_q [2];

  // Count mismatching cycles; flip on the DEBOUNCE_CYCLES-th consecutive one.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbLast) begin
          filt_q[i]   <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync2_q;
`endif

  assign edge_det   = filt & ~filt_prev_q;
  assign left_edge  = edge_det[0];
  assign right_edge = edge_det[1];

  typedef enum logic [0:0] {StIdle, StArmed} state_e;

  state_e               state_q, state_d;
  logic [MAX_WIDTH-1:0] win_q, win_d;
  logic                 first_d, second_d, timeout_d;

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    first_d   = 1'b0;
    second_d  = 1'b0;
    timeout_d = 1'b0;
    if (current_mode == OFF_MODE) begin
      state_d = StIdle;
      win_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (left_edge && !right_edge) begin
            first_d = 1'b1;
            win_d   = gesture_window;
            state_d = StArmed;
          end
        end
        StArmed: begin
          if (right_edge && !left_edge) begin
            second_d = 1'b1;
            win_d    = '0;
            state_d  = StIdle;
          end else if (left_edge && !right_edge) begin
            first_d = 1'b1;
            win_d   = gesture_window;
          end else if (win_q <= WinOne) begin
            // Decrementing to (or sitting at) zero ends the window this cycle.
            timeout_d = 1'b1;
            win_d     = '0;
            state_d   = StIdle;
          end else begin
            win_d = win_q - WinOne;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q              <= StIdle;
      win_q                <= '0;
      first_toggle_signal  <= 1'b0;
      second_toggle_signal <= 1'b0;
      gesture_timeout      <= 1'b0;
      gesture_armed        <= 1'b0;
    end else begin
      state_q              <= state_d;
      win_q                <= win_d;
      first_toggle_signal  <= first_d;
      second_toggle_signal <= second_d;
      gesture_timeout      <= timeout_d;
      gesture_armed        <= (state_d == StArmed);
    end
  end

endmodule

// File: tb/tb_gesture_toggle_generator.sv
// Randomized bench for gesture_toggle_generator with a behavioural model and directed scenarios.
// Works for builds with and without GESTURE_DEBOUNCE_EN.
module tb_gesture_toggle_generator;

  localparam int DB = 8;
`ifdef GESTURE_DEBOUNCE_EN
  localparam int D = DB;
`else
  localparam int D = 0;
`endif
  localparam int LAT = 3 + D;
  localparam logic [1:0] OFF = 2'd0;
  localparam logic [1:0] ON  = 2'd1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       left_sensor_raw = 1'b0;
  logic       right_sensor_raw = 1'b0;
  logic [1:0] current_mode = ON;
  logic [7:0] gesture_window = 8'd100;
  logic       first_toggle_signal, second_toggle_signal, gesture_armed, gesture_timeout;

  gesture_toggle_generator #(
    .DEBOUNCE_CYCLES(DB),
    .MODE_WIDTH     (2),
    .MAX_WIDTH      (8),
    .OFF_MODE       (OFF)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .left_sensor_raw     (left_sensor_raw),
    .right_sensor_raw    (right_sensor_raw),
    .current_mode        (current_mode),
    .gesture_window      (gesture_window),
    .first_toggle_signal (first_toggle_signal),
    .second_toggle_signal(second_toggle_signal),
    .gesture_armed       (gesture_armed),
    .gesture_timeout     (gesture_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  bit [1:0] m_s1, m_s2, m_f, m_fp;
  bit       hist [2][256];
  bit       m_armed;
  int       m_cyc = 0;
  int       m_deadline;
  bit       exp_first, exp_second, exp_armed, exp_timeout;
  bit       model_ok = 0;

  always @(posedge clk) begin
    bit [1:0] rawv, nf, ed;
    bit       all_diff;
    int       w;
    m_cyc++;
    exp_first   = 0;
    exp_second  = 0;
    exp_timeout = 0;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_f = 0; m_fp = 0; m_armed = 0;
      for (int c = 0; c < 2; c++) for (int i = 0; i < 256; i++) hist[c][i] = 0;
    end else begin
      rawv = {right_sensor_raw, left_sensor_raw};
      ed   = m_f & ~m_fp;
      // Filtered level flips once the last D synchronized samples all disagree with it.
      for (int c = 0; c < 2; c++) begin
        if (D == 0) begin
          nf[c] = m_s1[c];
        end else begin
          for (int i = 255; i > 0; i--) hist[c][i] = hist[c][i-1];
          hist[c][0] = m_s2[c];
          all_diff = 1;
          for (int i = 0; i < D; i++) if (hist[c][i] == m_f[c]) all_diff = 0;
          nf[c] = all_diff ? ~m_f[c] : m_f[c];
        end
      end
      m_fp = m_f;
      m_f  = nf;
      m_s2 = m_s1;
      m_s1 = rawv;
      w = (gesture_window == 0) ? 1 : int'(gesture_window);
      if (current_mode == OFF) begin
        m_armed = 0;
      end else if (!m_armed) begin
        if (ed[0] && !ed[1]) begin
          exp_first = 1; m_armed = 1; m_deadline = m_cyc + w;
        end
      end else begin
        if (ed[1] && !ed[0]) begin
          exp_second = 1; m_armed = 0;
        end else if (ed[0] && !ed[1]) begin
          exp_first = 1; m_deadline = m_cyc + w;
        end else if (m_cyc >= m_deadline) begin
          exp_timeout = 1; m_armed = 0;
        end
      end
    end
    exp_armed = m_armed;
    model_ok  = 1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_first",   int'(first_toggle_signal),  int'(exp_first));
      chk("model_second",  int'(second_toggle_signal), int'(exp_second));
      chk("model_armed",   int'(gesture_armed),        int'(exp_armed));
      chk("model_timeout", int'(gesture_timeout),      int'(exp_timeout));
    end
  end

  // ---------------- directed + random stimulus ----------------
  int cyc = 0;
  int n_first = 0, n_second = 0, n_to = 0;
  int last_first = -1, last_to = -1;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (first_toggle_signal) begin n_first++; last_first = cyc; end
    if (second_toggle_signal) n_second++;
    if (gesture_timeout) begin n_to++; last_to = cyc; end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int c0, f0, s0, t0, lat, seg;
    @(negedge clk);
    ticks(3);
    rst = 1'b0;
    chk("reset_first",   int'(first_toggle_signal),  0);
    chk("reset_second",  int'(second_toggle_signal), 0);
    chk("reset_armed",   int'(gesture_armed),        0);
    chk("reset_timeout", int'(gesture_timeout),      0);
    ticks(2);

    // Left swipe held 20 cycles, window 100.
    gesture_window = 8'd100;
    f0 = n_first; c0 = cyc; last_first = -1;
    left_sensor_raw = 1'b1;
    ticks(20);
    left_sensor_raw = 1'b0;
    lat = (last_first < 0) ? -1 : last_first - c0;
    chk("first_latency", lat, LAT);
    chk("first_once", n_first - f0, 1);
    chk("armed_after_first", int'(gesture_armed), 1);
    ticks(30 - (20 - LAT));
    // Right swipe 30 cycles after the first pulse.
    s0 = n_second; t0 = n_to;
    right_sensor_raw = 1'b1;
    ticks(20);
    right_sensor_raw = 1'b0;
    chk("second_once", n_second - s0, 1);
    chk("no_timeout_second", n_to - t0, 0);
    chk("disarmed_after_second", int'(gesture_armed), 0);
    ticks(15);

    // Window 5, no second gesture.
    gesture_window = 8'd5;
    f0 = n_first; t0 = n_to; last_first = -1; last_to = -1;
    left_sensor_raw = 1'b1;
    ticks(20);
    left_sensor_raw = 1'b0;
    chk("window5_first", n_first - f0, 1);
    chk("window5_timeout", n_to - t0, 1);
    chk("window5_delay", last_to - last_first, 5);
    chk("window5_disarmed", int'(gesture_armed), 0);
    ticks(15);

    // Short glitch on the left sensor.
    f0 = n_first;
    left_sensor_raw = 1'b1;
    ticks(4);
    left_sensor_raw = 1'b0;
    ticks(16);
    chk("glitch_first", n_first - f0, (D > 4) ? 0 : 1);
    ticks(10);

    // Simultaneous rising edges from IDLE.
    f0 = n_first; s0 = n_second;
    left_sensor_raw = 1'b1; right_sensor_raw = 1'b1;
    ticks(20);
    left_sensor_raw = 1'b0; right_sensor_raw = 1'b0;
    chk("both_first", n_first - f0, 0);
    chk("both_second", n_second - s0, 0);
    chk("both_idle", int'(gesture_armed), 0);
    ticks(15);

    // OFF_MODE while armed suppresses the second gesture.
    gesture_window = 8'd100;
    left_sensor_raw = 1'b1;
    ticks(20);
    left_sensor_raw = 1'b0;
    chk("off_pre_armed", int'(gesture_armed), 1);
    current_mode = OFF;
    tick();
    chk("off_disarms", int'(gesture_armed), 0);
    s0 = n_second;
    right_sensor_raw = 1'b1;
    ticks(20);
    right_sensor_raw = 1'b0;
    ticks(15);
    chk("off_no_second", n_second - s0, 0);
    current_mode = ON;
    ticks(15);
    chk("off_stays_idle", int'(gesture_armed), 0);

    // One-cycle left pulse.
    f0 = n_first; c0 = cyc; last_first = -1;
    left_sensor_raw = 1'b1;
    tick();
    left_sensor_raw = 1'b0;
    ticks(15);
    lat = (last_first < 0) ? -1 : last_first - c0;
    chk("short_pulse_count", n_first - f0, (D > 0) ? 0 : 1);
    chk("short_pulse_latency", lat, (D > 0) ? -1 : 3);
    ticks(110);

    // Randomized segments, including mid-sequence resets and OFF_MODE.
    for (int s = 0; s < 150; s++) begin
      left_sensor_raw  = 1'($urandom_range(0, 1));
      right_sensor_raw = 1'($urandom_range(0, 1));
      gesture_window   = 8'($urandom_range(0, 20));
      current_mode     = ($urandom_range(0, 9) == 0) ? OFF : 2'($urandom_range(1, 3));
      rst              = ($urandom_range(0, 24) == 0);
      seg = $urandom_range(1, 25);
      tick();
      rst = 1'b0;
      ticks(seg);
    end
    left_sensor_raw = 1'b0; right_sensor_raw = 1'b0;
    ticks(30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
